imply_stack: RTL and testbench

//   LIFO buffer of implied assignments, directly downstream of the conflict

---
 rtl/sat_pkg.sv | 46 ++++
 rtl/imply_stack.sv | 114 +++++++++++
 tb/tb_imply_stack.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sat_pkg.sv
// Shared SAT-solver types: implication entry layout, stack depth and the
// per-cycle operation decode used by imply_stack.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

package sat_pkg;

  localparam int unsigned IMPLY_STACK_DEPTH = 64;

  typedef struct packed {
    logic [`MAX_VARS_BITS-1:0] var_idx;
    logic                      val;
  } imply_entry_t;

  // One resolved stack action per cycle.
  typedef enum logic [2:0] {
    IMPLY_OP_HOLD,
    IMPLY_OP_FLUSH,
    IMPLY_OP_PUSH,
    IMPLY_OP_DROP,
    IMPLY_OP_POP,
    IMPLY_OP_REPLACE
  } imply_op_t;

  // Flush dominates; push+pop on a non-empty stack rewrites the top in
  // place; push+pop on an empty stack degenerates to a plain push.
  function automatic imply_op_t imply_decode(input logic flush,
                                             input logic push,
                                             input logic pop,
                                             input logic empty,
                                             input logic full);
    imply_op_t op;
    op = IMPLY_OP_HOLD;
    if (flush)
      op = IMPLY_OP_FLUSH;
    else if (push && pop && !empty)
      op = IMPLY_OP_REPLACE;
    else if (push)
      op = full ? IMPLY_OP_DROP : IMPLY_OP_PUSH;
    else if (pop && !empty)
      op = IMPLY_OP_POP;
    return op;
  endfunction

endpackage

// File: rtl/imply_stack.sv
// LIFO of implied (var_idx, val) assignments between the conflict detector
// and the solver. Optional high-water-mark output: define IMPLY_STACK_HWM_EN.
module imply_stack
  import sat_pkg::*;
#(
  parameter int unsigned DEPTH = IMPLY_STACK_DEPTH,
  parameter int unsigned VAR_W = `MAX_VARS_BITS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_en,
  input  logic [VAR_W-1:0]       push_var_idx,
  input  logic                   push_val,
  input  logic                   pop_en,
  input  logic                   flush,
  output logic                   top_valid,
  output logic [VAR_W-1:0]       top_var_idx,
  output logic                   top_val,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
`ifdef IMPLY_STACK_HWM_EN
  ,
  output logic [$clog2(DEPTH):0] hwm
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned SP_W  = PTR_W + 1;

  imply_entry_t            mem [DEPTH];
  imply_entry_t            push_entry;
  imply_entry_t            top_entry;
  imply_op_t               op;
  logic [SP_W-1:0]         sp;
  logic [SP_W-1:0]         sp_nxt;
  logic                    ovf_nxt;
  logic                    wr_en;
  logic [PTR_W-1:0]        wr_addr;
  logic [PTR_W-1:0]        top_addr;

  assign empty    = (sp == '0);
  assign full     = (sp == SP_W'(DEPTH));
  assign count    = sp;
  // When full, sp's low bits wrap to 0 so top_addr lands on DEPTH-1.
  assign top_addr = sp[PTR_W-1:0] - PTR_W'(1);

  assign push_entry = '{var_idx: push_var_idx, val: push_val};

  // Resolve this cycle's action into next pointer/flag and a write strobe.
  always_comb begin
    op      = imply_decode(flush, push_en, pop_en, empty, full);
    sp_nxt  = sp;
    ovf_nxt = overflow;
    wr_en   = 1'b0;
    wr_addr = sp[PTR_W-1:0];
    case (op)
      IMPLY_OP_FLUSH: begin
        sp_nxt  = '0;
        ovf_nxt = 1'b0;
      end
      IMPLY_OP_PUSH: begin
        wr_en   = 1'b1;
        wr_addr = sp[PTR_W-1:0];
        sp_nxt  = sp + SP_W'(1);
      end
      IMPLY_OP_DROP: begin
        ovf_nxt = 1'b1;
      end
      IMPLY_OP_POP: begin
        sp_nxt  = sp - SP_W'(1);
      end
      IMPLY_OP_REPLACE: begin
        wr_en   = 1'b1;
        wr_addr = top_addr;
      end
      default: ;
    endcase
  end

  // Stack pointer, sticky overflow and (optionally) high-water mark.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sp       <= '0;
      overflow <= 1'b0;
`ifdef IMPLY_STACK_HWM_EN
      hwm      <= '0;
`endif
    end else begin
      sp       <= sp_nxt;
      overflow <= ovf_nxt;
`ifdef IMPLY_STACK_HWM_EN
      if (sp_nxt > hwm)
        hwm <= sp_nxt;
`endif
    end
  end

  // Entry storage; contents are deliberately left unreset.
  always_ff @(posedge clock) begin
    if (wr_en && reset)
      mem[wr_addr] <= push_entry;
  end

  // Present the newest entry, zeroed while the stack is empty.
  always_comb begin
    top_entry   = empty ? '0 : mem[top_addr];
    top_valid   = !empty;
    top_var_idx = top_entry.var_idx;
    top_val     = top_entry.val;
  end

endmodule

// File: tb/tb_imply_stack.sv
// Self-checking bench for imply_stack: table of vectors, scoreboard of
// expected top/count/flag snapshots, plus hand sequences for fill/overflow,
// async reset and (when IMPLY_STACK_HWM_EN is defined) the high-water mark.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

module tb_imply_stack;

  localparam int VW = `MAX_VARS_BITS;
  localparam int D  = 64;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 push_en;
  logic [VW-1:0]        push_var_idx;
  logic                 push_val;
  logic                 pop_en;
  logic                 flush;
  logic                 top_valid;
  logic [VW-1:0]        top_var_idx;
  logic                 top_val;
  logic                 empty;
  logic                 full;
  logic [$clog2(D):0]   count;
  logic                 overflow;
`ifdef IMPLY_STACK_HWM_EN
  logic [$clog2(D):0]   hwm;
`endif

  imply_stack #(.DEPTH(D), .VAR_W(VW)) dut (
    .clock        (clock),
    .reset        (reset),
    .push_en      (push_en),
    .push_var_idx (push_var_idx),
    .push_val     (push_val),
    .pop_en       (pop_en),
    .flush        (flush),
    .top_valid    (top_valid),
    .top_var_idx  (top_var_idx),
    .top_val      (top_val),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow)
`ifdef IMPLY_STACK_HWM_EN
    ,
    .hwm          (hwm)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int            cnt;
    logic          tv;
    logic [VW-1:0] vidx;
    logic          val;
    logic          ovf;
  } exp_t;

  typedef struct {
    string         tag;
    logic          push;
    logic [VW-1:0] vi;
    logic          v;
    logic          pop;
    logic          fl;
    exp_t          e;
  } vec_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t mk(input int c, input logic tv, input int vi,
                              input logic v, input logic o);
    exp_t e;
    e.cnt  = c;
    e.tv   = tv;
    e.vidx = VW'(vi);
    e.val  = v;
    e.ovf  = o;
    return e;
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Pop one expected snapshot and compare every observable output.
  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check_int({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    check_int({tag, "_count"},     int'(count),       e.cnt);
    check_int({tag, "_top_valid"}, int'(top_valid),   int'(e.tv));
    check_int({tag, "_top_var"},   int'(top_var_idx), int'(e.vidx));
    check_int({tag, "_top_val"},   int'(top_val),     int'(e.val));
    check_int({tag, "_overflow"},  int'(overflow),    int'(e.ovf));
    check_int({tag, "_empty"},     int'(empty),       int'(e.cnt == 0));
    check_int({tag, "_full"},      int'(full),        int'(e.cnt == D));
  endtask

  task automatic step(input string tag, input logic p, input logic [VW-1:0] vi,
                      input logic v, input logic po, input logic fl,
                      input exp_t e);
    @(negedge clock);
    push_en      = p;
    push_var_idx = vi;
    push_val     = v;
    pop_en       = po;
    flush        = fl;
    sb.push_back(e);
    @(posedge clock);
    #1;
    compare(tag);
  endtask

  task automatic idle_inputs();
    push_en      = 1'b0;
    push_var_idx = '0;
    push_val     = 1'b0;
    pop_en       = 1'b0;
    flush        = 1'b0;
  endtask

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{"t1_push5",   1, 5, 1, 0, 0, mk(1, 1, 5, 1, 0)};
    tbl[1]  = '{"t1_push9",   1, 9, 0, 0, 0, mk(2, 1, 9, 0, 0)};
    tbl[2]  = '{"t1_push3",   1, 3, 1, 0, 0, mk(3, 1, 3, 1, 0)};
    tbl[3]  = '{"t1_pop1",    0, 0, 0, 1, 0, mk(2, 1, 9, 0, 0)};
    tbl[4]  = '{"t1_pop2",    0, 0, 0, 1, 0, mk(1, 1, 5, 1, 0)};
    tbl[5]  = '{"t1_pop3",    0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0)};
    tbl[6]  = '{"t3_push2",   1, 2, 0, 0, 0, mk(1, 1, 2, 0, 0)};
    tbl[7]  = '{"t3_repl4",   1, 4, 1, 1, 0, mk(1, 1, 4, 1, 0)};
    tbl[8]  = '{"t3_pop",     0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0)};
    tbl[9]  = '{"t3_pop_emp", 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0)};
    tbl[10] = '{"t4_pushfl",  1, 8, 1, 0, 1, mk(0, 0, 0, 0, 0)};
    tbl[11] = '{"t4_pp_emp",  1, 6, 1, 1, 0, mk(1, 1, 6, 1, 0)};
    tbl[12] = '{"t4_flush",   0, 0, 0, 1, 1, mk(0, 0, 0, 0, 0)};

    idle_inputs();
    reset = 1'b0;
    #12;
    sb.push_back(mk(0, 0, 0, 0, 0));
    compare("reset");
    @(negedge clock);
    reset = 1'b1;

    // Basic push/pop, replace-top, empty pop, flush priority
    for (int unsigned k = 0; k < 13; k++)
      step(tbl[k].tag, tbl[k].push, tbl[k].vi, tbl[k].v, tbl[k].pop,
           tbl[k].fl, tbl[k].e);

    // Fill to full, then overflow and flush
    for (int i = 0; i < D; i++)
      step("t2_fill", 1, VW'(i), i[0], 0, 0, mk(i + 1, 1, i, i[0], 0));
    step("t2_over",  1, 7, 1, 0, 0, mk(D, 1, 63, 1, 1));
    step("t2_flush", 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0));

    // Replace-top while full must not raise overflow
    for (int i = 0; i < D; i++)
      step("t2_refill", 1, VW'(i), i[0], 0, 0, mk(i + 1, 1, i, i[0], 0));
    step("t2_repl_full", 1, 10, 0, 1, 0, mk(D, 1, 10, 0, 0));
    step("t2_pop_full",  0, 0, 0, 1, 0, mk(D - 1, 1, 62, 0, 0));
    step("t2_flush2",    0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0));

    // Asynchronous reset between edges
    step("t5_p1", 1, 1, 1, 0, 0, mk(1, 1, 1, 1, 0));
    step("t5_p2", 1, 2, 0, 0, 0, mk(2, 1, 2, 0, 0));
    step("t5_p3", 1, 3, 1, 0, 0, mk(3, 1, 3, 1, 0));
    @(negedge clock);
    idle_inputs();
    #2;
    reset = 1'b0;
    #1;
    sb.push_back(mk(0, 0, 0, 0, 0));
    compare("t5_async");
    @(negedge clock);
    reset = 1'b1;
    step("t5_after", 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0));

`ifdef IMPLY_STACK_HWM_EN
    check_int("t6_hwm_reset", int'(hwm), 0);
    for (int i = 0; i < 10; i++)
      step("t6_push", 1, VW'(i + 20), 1, 0, 0, mk(i + 1, 1, i + 20, 1, 0));
    for (int i = 0; i < 4; i++)
      step("t6_pop", 0, 0, 0, 1, 0, mk(9 - i, 1, 28 - i, 1, 0));
    step("t6_flush", 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0));
    check_int("t6_hwm_flush", int'(hwm), 10);
    step("t6_pa", 1, 40, 0, 0, 0, mk(1, 1, 40, 0, 0));
    step("t6_pb", 1, 41, 1, 0, 0, mk(2, 1, 41, 1, 0));
    check_int("t6_hwm", int'(hwm), 10);
`endif

    check_int("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
